ysyx_rob_mw: RTL and testbench

YSYX_ROB_MW -- requirements
Module: ysyx_rob_mw

---
 rtl/ysyx_rob_mw.sv | 206 ++++++++++++++++++++
 tb/tb_ysyx_rob_mw.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_rob_mw.sv
// rtl/ysyx_rob_mw.sv - reorder buffer with rename table, multi-port writeback and mispredict flush
//   clock, reset                  : rising-edge clock, asynchronous active-high reset
//   disp_*                        : in-order allocation at tail, disp_tag returns the slot
//   rs1_*/rs2_*                   : combinational operand lookup with writeback forwarding
//   wb_*                          : NUM_WB packed writeback ports (value and resolved npc)
//   cm_*                          : in-order commit from head
//   flush, flush_pc, count        : redirect pulse, redirect target, occupancy
module ysyx_rob_mw #(
    parameter int XLEN     = 32,
    parameter int ROB_SIZE = 8,
    parameter int REG_NUM  = 16,
    parameter int NUM_WB   = 2,
    localparam int TW      = $clog2(ROB_SIZE),
    localparam int RL      = $clog2(REG_NUM)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic [RL-1:0]          disp_rd,
    input  logic [XLEN-1:0]        disp_pc,
    input  logic [XLEN-1:0]        disp_pnpc,
    output logic [TW-1:0]          disp_tag,
    input  logic [RL-1:0]          rs1_idx,
    output logic                   rs1_busy,
    output logic                   rs1_ready,
    output logic [TW-1:0]          rs1_tag,
    output logic [XLEN-1:0]        rs1_value,
    input  logic [RL-1:0]          rs2_idx,
    output logic                   rs2_busy,
    output logic                   rs2_ready,
    output logic [TW-1:0]          rs2_tag,
    output logic [XLEN-1:0]        rs2_value,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*TW-1:0]   wb_tag,
    input  logic [NUM_WB*XLEN-1:0] wb_value,
    input  logic [NUM_WB*XLEN-1:0] wb_npc,
    output logic                   cm_valid,
    input  logic                   cm_ready,
    output logic [RL-1:0]          cm_rd,
    output logic [XLEN-1:0]        cm_value,
    output logic [XLEN-1:0]        cm_pc,
    output logic [XLEN-1:0]        cm_npc,
    output logic                   flush,
    output logic [XLEN-1:0]        flush_pc,
    output logic [TW:0]            count
);

    typedef enum logic [1:0] {ST_FREE, ST_EX, ST_WB} ent_st_e;

    ent_st_e         st_q     [ROB_SIZE];
    logic [RL-1:0]   rd_q     [ROB_SIZE];
    logic [XLEN-1:0] pc_q     [ROB_SIZE];
    logic [XLEN-1:0] pnpc_q   [ROB_SIZE];
    logic [XLEN-1:0] val_q    [ROB_SIZE];
    logic [XLEN-1:0] npc_q    [ROB_SIZE];
    logic            busy_q   [REG_NUM];
    logic [TW-1:0]   rtag_q   [REG_NUM];
    logic [TW-1:0]   head_q, tail_q;
    logic [TW:0]     cnt_q;
    logic            flush_q;
    logic [XLEN-1:0] flush_pc_q;

    // Per-entry writeback resolution; ports are scanned high to low so the
    // lowest-indexed port writing a tag is the one that sticks.
    logic            wb_hit   [ROB_SIZE];
    logic [XLEN-1:0] wb_val_e [ROB_SIZE];
    logic [XLEN-1:0] wb_npc_e [ROB_SIZE];

    always_comb begin
        for (int e = 0; e < ROB_SIZE; e++) begin
            wb_hit[e]   = 1'b0;
            wb_val_e[e] = '0;
            wb_npc_e[e] = '0;
            for (int i = NUM_WB - 1; i >= 0; i--) begin
                if (wb_valid[i] && wb_tag[i*TW +: TW] == TW'(e)) begin
                    wb_hit[e]   = 1'b1;
                    wb_val_e[e] = wb_value[i*XLEN +: XLEN];
                    wb_npc_e[e] = wb_npc[i*XLEN +: XLEN];
                end
            end
        end
    end

    logic do_disp, do_cm, mispredict;

    assign disp_ready = (cnt_q < (TW+1)'(ROB_SIZE)) && !flush_q;
    assign disp_tag   = tail_q;
    assign do_disp    = disp_valid && disp_ready;
    assign cm_valid   = (st_q[head_q] == ST_WB) && !flush_q;
    assign cm_rd      = rd_q[head_q];
    assign cm_value   = val_q[head_q];
    assign cm_pc      = pc_q[head_q];
    assign cm_npc     = npc_q[head_q];
    assign do_cm      = cm_valid && cm_ready;
    assign mispredict = npc_q[head_q] != pnpc_q[head_q];
    assign flush      = flush_q;
    assign flush_pc   = flush_pc_q;
    assign count      = cnt_q;

    // Operand lookup sees registered state only; forwarding comes from the
    // writeback ports of this cycle.
    logic [RL-1:0]   lk_idx   [2];
    logic            lk_busy  [2];
    logic            lk_ready [2];
    logic [TW-1:0]   lk_tag   [2];
    logic [XLEN-1:0] lk_value [2];

    assign lk_idx[0] = rs1_idx;
    assign lk_idx[1] = rs2_idx;

    always_comb begin
        for (int x = 0; x < 2; x++) begin
            lk_busy[x]  = 1'b0;
            lk_ready[x] = 1'b1;
            lk_tag[x]   = '0;
            lk_value[x] = '0;
            if (lk_idx[x] != '0 && busy_q[lk_idx[x]]) begin
                lk_busy[x]  = 1'b1;
                lk_tag[x]   = rtag_q[lk_idx[x]];
                lk_ready[x] = 1'b0;
                if (st_q[rtag_q[lk_idx[x]]] == ST_WB) begin
                    lk_ready[x] = 1'b1;
                    lk_value[x] = val_q[rtag_q[lk_idx[x]]];
                end else if (wb_hit[rtag_q[lk_idx[x]]] && !flush_q) begin
                    lk_ready[x] = 1'b1;
                    lk_value[x] = wb_val_e[rtag_q[lk_idx[x]]];
                end
            end
        end
    end

    assign rs1_busy  = lk_busy[0];
    assign rs1_ready = lk_ready[0];
    assign rs1_tag   = lk_tag[0];
    assign rs1_value = lk_value[0];
    assign rs2_busy  = lk_busy[1];
    assign rs2_ready = lk_ready[1];
    assign rs2_tag   = lk_tag[1];
    assign rs2_value = lk_value[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < ROB_SIZE; e++) st_q[e] <= ST_FREE;
            for (int r = 0; r < REG_NUM; r++) begin
                busy_q[r] <= 1'b0;
                rtag_q[r] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else if (flush_q) begin
            // Redirect cycle: drop everything in flight, writebacks included.
            for (int e = 0; e < ROB_SIZE; e++) st_q[e] <= ST_FREE;
            for (int r = 0; r < REG_NUM; r++) busy_q[r] <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            for (int e = 0; e < ROB_SIZE; e++) begin
                if (wb_hit[e] && st_q[e] == ST_EX) st_q[e] <= ST_WB;
            end
            // Commit clears the mapping first so a same-cycle dispatch to the
            // same rd overrides it.
            if (do_cm) begin
                st_q[head_q] <= ST_FREE;
                head_q       <= head_q + TW'(1);
                if (rtag_q[cm_rd] == head_q) busy_q[cm_rd] <= 1'b0;
            end
            if (do_disp) begin
                st_q[tail_q] <= ST_EX;
                tail_q       <= tail_q + TW'(1);
                if (disp_rd != '0) begin
                    busy_q[disp_rd] <= 1'b1;
                    rtag_q[disp_rd] <= tail_q;
                end
            end
            case ({do_disp, do_cm})
                2'b10:   cnt_q <= cnt_q + (TW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (TW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            flush_q <= do_cm && mispredict;
            if (do_cm && mispredict) flush_pc_q <= npc_q[head_q];
        end
    end

    // Payload storage needs no reset: it is only observed through entry state.
    always_ff @(posedge clock) begin
        for (int e = 0; e < ROB_SIZE; e++) begin
            if (!flush_q && wb_hit[e] && st_q[e] == ST_EX) begin
                val_q[e] <= wb_val_e[e];
                npc_q[e] <= wb_npc_e[e];
            end
        end
        if (do_disp) begin
            rd_q[tail_q]   <= disp_rd;
            pc_q[tail_q]   <= disp_pc;
            pnpc_q[tail_q] <= disp_pnpc;
        end
    end

endmodule

// File: tb/tb_ysyx_rob_mw.sv
// tb/tb_ysyx_rob_mw.sv - self-checking bench for ysyx_rob_mw
module tb_ysyx_rob_mw;

    logic        clock, reset;
    logic        disp_valid, disp_ready;
    logic [3:0]  disp_rd;
    logic [31:0] disp_pc, disp_pnpc;
    logic [2:0]  disp_tag;
    logic [3:0]  rs1_idx, rs2_idx;
    logic        rs1_busy, rs1_ready, rs2_busy, rs2_ready;
    logic [2:0]  rs1_tag, rs2_tag;
    logic [31:0] rs1_value, rs2_value;
    logic [1:0]  wb_valid;
    logic [5:0]  wb_tag;
    logic [63:0] wb_value, wb_npc;
    logic        cm_valid, cm_ready;
    logic [3:0]  cm_rd;
    logic [31:0] cm_value, cm_pc, cm_npc;
    logic        flush;
    logic [31:0] flush_pc;
    logic [3:0]  count;

    ysyx_rob_mw #(.XLEN(32), .ROB_SIZE(8), .REG_NUM(16), .NUM_WB(2)) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
        .disp_pc(disp_pc), .disp_pnpc(disp_pnpc), .disp_tag(disp_tag),
        .rs1_idx(rs1_idx), .rs1_busy(rs1_busy), .rs1_ready(rs1_ready),
        .rs1_tag(rs1_tag), .rs1_value(rs1_value),
        .rs2_idx(rs2_idx), .rs2_busy(rs2_busy), .rs2_ready(rs2_ready),
        .rs2_tag(rs2_tag), .rs2_value(rs2_value),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_npc(wb_npc),
        .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_rd(cm_rd),
        .cm_value(cm_value), .cm_pc(cm_pc), .cm_npc(cm_npc),
        .flush(flush), .flush_pc(flush_pc), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] val;
        logic [31:0] pc;
        logic [31:0] npc;
    } rec_t;
    rec_t sb[$];

    typedef struct {
        logic       disp;
        logic [3:0] rd;
        logic [1:0] wbv;
        logic [2:0] wt0, wt1;
        logic [1:0] bad;
        logic       cmr;
        logic       exp_ready;
        logic [2:0] exp_tag;
        logic       exp_cmv;
        logic [3:0] exp_cnt;
    } vec_t;
    vec_t vecs[18];

    logic [31:0] m_val[8];
    logic [31:0] m_npc[8];
    logic [31:0] pc_ctr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0; disp_rd = '0; disp_pc = '0; disp_pnpc = '0;
        wb_valid = '0; wb_tag = '0; wb_value = '0; wb_npc = '0;
        cm_ready = 1'b0;
    endtask

    task automatic prep_disp(input int tag, input logic [3:0] rd, input logic [31:0] pc,
                             input logic [31:0] pnpc, input logic [31:0] npc,
                             input logic [31:0] val, input bit push);
        disp_valid = 1'b1; disp_rd = rd; disp_pc = pc; disp_pnpc = pnpc;
        if (push) begin
            m_val[tag] = val;
            m_npc[tag] = npc;
            sb.push_back('{rd: rd, val: val, pc: pc, npc: npc});
        end
    endtask

    task automatic set_wb(input int port, input int tag, input bit bad);
        wb_valid[port]        = 1'b1;
        wb_tag[port*3 +: 3]   = 3'(tag);
        wb_value[port*32 +: 32] = bad ? ~m_val[tag] : m_val[tag];
        wb_npc[port*32 +: 32]   = bad ? (m_npc[tag] ^ 32'h4) : m_npc[tag];
    endtask

    task automatic setv(input int i, input logic d, input logic [3:0] rd, input logic [1:0] wbv,
                        input logic [2:0] t0, input logic [2:0] t1, input logic [1:0] bad,
                        input logic cmr, input logic er, input logic [2:0] et,
                        input logic ec, input logic [3:0] ecnt);
        vecs[i] = '{d, rd, wbv, t0, t1, bad, cmr, er, et, ec, ecnt};
    endtask

    // Commit scoreboard: every handshake must match the oldest outstanding dispatch.
    always @(negedge clock) begin
        if (!reset && cm_valid && cm_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected: got commit rd %0d expected none", cm_rd);
            end else begin
                rec_t r;
                r = sb.pop_front();
                chk("cm_rd", 64'(cm_rd), 64'(r.rd));
                chk("cm_value", 64'(cm_value), 64'(r.val));
                chk("cm_pc", 64'(cm_pc), 64'(r.pc));
                chk("cm_npc", 64'(cm_npc), 64'(r.npc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle();
        rs1_idx = '0; rs2_idx = '0;
        pc_ctr = 32'h8000_0000;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("rst_disp_tag", 64'(disp_tag), 64'd0);
        chk("rst_cm_valid", 64'(cm_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_flush_pc", 64'(flush_pc), 64'd0);
        reset = 1'b0;
        tick();

        // Fill, reject when full, out-of-order writeback, ignored rewrites, port priority, drain.
        for (int i = 0; i < 8; i++) setv(i, 1, 4'(i + 2), 2'b00, 0, 0, 2'b00, 0, 1, 3'(i), 0, 4'(i));
        setv(8,  1, 9, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 8);
        setv(9,  0, 0, 2'b01, 2, 0, 2'b00, 0, 0, 0, 0, 8);
        setv(10, 0, 0, 2'b11, 2, 0, 2'b01, 0, 0, 0, 0, 8);
        setv(11, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 8);
        setv(12, 0, 0, 2'b00, 0, 0, 2'b00, 1, 0, 0, 1, 8);
        setv(13, 0, 0, 2'b00, 0, 0, 2'b00, 1, 1, 0, 0, 7);
        setv(14, 0, 0, 2'b11, 1, 1, 2'b10, 1, 1, 0, 0, 7);
        setv(15, 0, 0, 2'b00, 0, 0, 2'b00, 1, 1, 0, 1, 7);
        setv(16, 0, 0, 2'b00, 0, 0, 2'b00, 1, 1, 0, 1, 6);
        setv(17, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1, 0, 0, 5);

        for (int i = 0; i < 18; i++) begin
            idle();
            if (vecs[i].disp) begin
                prep_disp(int'(vecs[i].exp_tag), vecs[i].rd, pc_ctr, pc_ctr + 32'd4, pc_ctr + 32'd4,
                          (vecs[i].exp_tag == 3'd3) ? 32'h0000_ABCD : $urandom, vecs[i].exp_ready);
                if (vecs[i].exp_ready) pc_ctr = pc_ctr + 32'd4;
            end
            if (vecs[i].wbv[0]) set_wb(0, int'(vecs[i].wt0), vecs[i].bad[0]);
            if (vecs[i].wbv[1]) set_wb(1, int'(vecs[i].wt1), vecs[i].bad[1]);
            cm_ready = vecs[i].cmr;
            #1;
            chk($sformatf("v%0d_disp_ready", i), 64'(disp_ready), 64'(vecs[i].exp_ready));
            chk($sformatf("v%0d_disp_tag", i), 64'(disp_tag), 64'(vecs[i].exp_tag));
            chk($sformatf("v%0d_cm_valid", i), 64'(cm_valid), 64'(vecs[i].exp_cmv));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].exp_cnt));
            tick();
        end

        // Same-cycle forward: rd5 -> tag3 still EX, port1 writes it now.
        idle();
        rs1_idx = 4'd5; rs2_idx = 4'd2;
        #1;
        chk("fwd_pre_busy", 64'(rs1_busy), 64'd1);
        chk("fwd_pre_tag", 64'(rs1_tag), 64'd3);
        chk("fwd_pre_ready", 64'(rs1_ready), 64'd0);
        chk("fwd_pre_value", 64'(rs1_value), 64'd0);
        chk("rs2_committed_busy", 64'(rs2_busy), 64'd0);
        chk("rs2_committed_ready", 64'(rs2_ready), 64'd1);
        set_wb(1, 3, 0);
        wb_tag[2:0] = 3'd3;
        #1;
        chk("fwd_ready", 64'(rs1_ready), 64'd1);
        chk("fwd_value", 64'(rs1_value), 64'h0000_ABCD);
        tick();
        idle();
        #1;
        chk("wbst_ready", 64'(rs1_ready), 64'd1);
        chk("wbst_value", 64'(rs1_value), 64'h0000_ABCD);

        // Rename race: commit rd7 (tag5) while dispatching rd7.
        set_wb(0, 4, 0);
        set_wb(1, 5, 0);
        cm_ready = 1'b1;
        #1;
        chk("rn_c1_cm_valid", 64'(cm_valid), 64'd1);
        tick();
        idle();
        cm_ready = 1'b1;
        #1;
        chk("rn_c2_cm_valid", 64'(cm_valid), 64'd1);
        tick();
        idle();
        cm_ready = 1'b1;
        prep_disp(0, 4'd7, pc_ctr, pc_ctr + 32'd4, pc_ctr + 32'd4, $urandom, 1);
        pc_ctr = pc_ctr + 32'd4;
        #1;
        chk("rn_c3_cm_valid", 64'(cm_valid), 64'd1);
        chk("rn_c3_cm_rd", 64'(cm_rd), 64'd7);
        chk("rn_c3_disp_tag", 64'(disp_tag), 64'd0);
        tick();
        idle();
        rs1_idx = 4'd7; rs2_idx = 4'd6;
        #1;
        chk("rn_busy7", 64'(rs1_busy), 64'd1);
        chk("rn_tag7", 64'(rs1_tag), 64'd0);
        chk("rn_ready7", 64'(rs1_ready), 64'd0);
        chk("rn_busy6_cleared", 64'(rs2_busy), 64'd0);
        chk("rn_count", 64'(count), 64'd3);

        // Bring occupancy to 5, then assert reset mid-cycle.
        for (int k = 1; k < 3; k++) begin
            tick();
            idle();
            prep_disp(k, 4'(9 + k), pc_ctr, pc_ctr + 32'd4, pc_ctr + 32'd4, $urandom, 1);
            pc_ctr = pc_ctr + 32'd4;
        end
        tick();
        idle();
        #1;
        chk("ar_pre_count", 64'(count), 64'd5);
        chk("sb_pending", 64'(sb.size()), 64'd5);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_cm_valid", 64'(cm_valid), 64'd0);
        chk("ar_disp_ready", 64'(disp_ready), 64'd1);
        chk("ar_disp_tag", 64'(disp_tag), 64'd0);
        chk("ar_busy7", 64'(rs1_busy), 64'd0);
        tick();
        reset = 1'b0;
        sb.delete();

        // Mispredict: pnpc 0x80000010, resolved npc 0x80000040.
        prep_disp(0, 4'd3, 32'h8000_000C, 32'h8000_0010, 32'h8000_0040, $urandom, 1);
        #1;
        chk("mp_d1_ready", 64'(disp_ready), 64'd1);
        chk("mp_d1_tag", 64'(disp_tag), 64'd0);
        tick();
        idle();
        prep_disp(1, 4'd4, 32'h8000_0010, 32'h8000_0014, 32'h8000_0014, $urandom, 1);
        set_wb(0, 0, 0);
        tick();
        idle();
        cm_ready = 1'b1;
        #1;
        chk("mp_cm_valid", 64'(cm_valid), 64'd1);
        chk("mp_cm_npc", 64'(cm_npc), 64'h8000_0040);
        chk("mp_pre_flush", 64'(flush), 64'd0);
        tick();
        idle();
        cm_ready = 1'b1;
        disp_valid = 1'b1; disp_rd = 4'd9;
        set_wb(0, 1, 0);
        rs1_idx = 4'd4;
        #1;
        chk("mp_flush", 64'(flush), 64'd1);
        chk("mp_flush_pc", 64'(flush_pc), 64'h8000_0040);
        chk("mp_fl_disp_ready", 64'(disp_ready), 64'd0);
        chk("mp_fl_cm_valid", 64'(cm_valid), 64'd0);
        chk("mp_fl_count", 64'(count), 64'd1);
        tick();
        idle();
        #1;
        chk("mp_post_flush", 64'(flush), 64'd0);
        chk("mp_post_count", 64'(count), 64'd0);
        chk("mp_post_disp_ready", 64'(disp_ready), 64'd1);
        chk("mp_post_disp_tag", 64'(disp_tag), 64'd0);
        chk("mp_post_busy4", 64'(rs1_busy), 64'd0);
        chk("mp_post_cm_valid", 64'(cm_valid), 64'd0);
        sb.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
